// File: rtl/complex_mult_pipe_if.sv
// Streaming port bundle for complex_mult_pipe: one operand beat in, one product beat out.
// Handshake: a beat moves on a rising edge where valid && ready; a source holds valid and data until then.
interface complex_mult_pipe_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x0_re;
    logic signed [DW-1:0] x0_im;
    logic signed [DW-1:0] x1_re;
    logic signed [DW-1:0] x1_im;
    logic                 conj_x1;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] res_re;
    logic signed [DW-1:0] res_im;
    logic                 sat;

    modport master (
        output in_valid, x0_re, x0_im, x1_re, x1_im, conj_x1, out_ready,
        input  in_ready, out_valid, res_re, res_im, sat
    );

    modport slave (
        input  in_valid, x0_re, x0_im, x1_re, x1_im, conj_x1, out_ready,
        output in_ready, out_valid, res_re, res_im, sat
    );
endinterface

// File: rtl/complex_mult_pipe.sv
// Three-stage fixed-point complex multiplier (operands, partial products, rounded/saturated
// result) with per-stage valid bits and collapsing bubbles.
module complex_mult_pipe #(
    parameter int DW        = 16,
    parameter int FRAC      = DW - 1,
    parameter int USE_GAUSS = 0,
    parameter int ROUND     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    complex_mult_pipe_if.slave   bus
);
    localparam int PW  = 2 * DW + 2;
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW:0]   ONE  = 1;
    localparam logic signed [PW:0]   RC   = (ROUND != 0 && FRAC > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [PW:0]   MAXV = {{(PW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW:0]   MINV = {{(PW+2-DW){1'b1}}, {(DW-1){1'b0}}};

    logic v1, v2, v3;
    logic en1, en2, en3;

    // A stage may load when it is empty or its content moves on this cycle.
    assign en3          = !v3 || bus.out_ready;
    assign en2          = !v2 || en3;
    assign en1          = !v1 || en2;
    assign bus.in_ready = en1 && !rst;

    // S1: operands, with the conjugate folded in
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [DW-1:0] b_im_in;

    assign b_im_in = !bus.conj_x1      ? bus.x1_im :
                     (bus.x1_im == DMIN) ? DMAX      : -bus.x1_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            a_re <= '0;
            a_im <= '0;
            b_re <= '0;
            b_im <= '0;
        end else if (en1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a_re <= bus.x0_re;
                a_im <= bus.x0_im;
                b_re <= bus.x1_re;
                b_im <= b_im_in;
            end
        end
    end

    // S2: exact products, wide enough that neither form loses a bit
    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] p_re_c, p_im_c;
    logic signed [PW-1:0] p_re, p_im;

    assign ar = PW'(a_re);
    assign ai = PW'(a_im);
    assign br = PW'(b_re);
    assign bi = PW'(b_im);

    if (USE_GAUSS != 0) begin : g_gauss
        logic signed [DW:0]   s_a, d_b, s_b;
        logic signed [PW-1:0] k1, k2, k3;

        assign s_a    = (DW+1)'(a_re) + (DW+1)'(a_im);
        assign d_b    = (DW+1)'(b_im) - (DW+1)'(b_re);
        assign s_b    = (DW+1)'(b_re) + (DW+1)'(b_im);
        assign k1     = br * PW'(s_a);
        assign k2     = ar * PW'(d_b);
        assign k3     = ai * PW'(s_b);
        assign p_re_c = k1 - k3;
        assign p_im_c = k1 + k2;
    end else begin : g_four
        assign p_re_c = ar * br - ai * bi;
        assign p_im_c = ar * bi + ai * br;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            p_re <= '0;
            p_im <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                p_re <= p_re_c;
                p_im <= p_im_c;
            end
        end
    end

    // S3: rescale to Q(FRAC) and clamp; MSB of the return flags a clamp.
    function automatic logic [DW:0] rescale(input logic signed [PW-1:0] p);
        logic signed [PW:0] t;
        t = (PW+1)'(p) + RC;
        t = t >>> FRAC;
        if (t > MAXV)      return {1'b1, DMAX};
        else if (t < MINV) return {1'b1, DMIN};
        else               return {1'b0, t[DW-1:0]};
    endfunction

    logic [DW:0]          r_re_c, r_im_c;
    logic signed [DW-1:0] res_re_q, res_im_q;
    logic                 sat_q;

    assign r_re_c = rescale(p_re);
    assign r_im_c = rescale(p_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            v3       <= 1'b0;
            res_re_q <= '0;
            res_im_q <= '0;
            sat_q    <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                res_re_q <= r_re_c[DW-1:0];
                res_im_q <= r_im_c[DW-1:0];
                sat_q    <= r_re_c[DW] | r_im_c[DW];
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.res_re    = res_re_q;
    assign bus.res_im    = res_im_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: four-multiplier and Gauss instances (rounding) plus a truncating
// Gauss instance share one stimulus stream and are checked against an integer reference model.
module tb_complex_mult_pipe;
    localparam int W = 33;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                d_rst;
    logic                d_valid, d_conj, d_ready;
    logic signed [15:0]  d_x0_re, d_x0_im, d_x1_re, d_x1_im;

    complex_mult_pipe_if #(.DW(16)) ifa ();
    complex_mult_pipe_if #(.DW(16)) ifb ();
    complex_mult_pipe_if #(.DW(16)) ifc ();

    assign ifa.in_valid = d_valid;  assign ifb.in_valid = d_valid;  assign ifc.in_valid = d_valid;
    assign ifa.x0_re    = d_x0_re;  assign ifb.x0_re    = d_x0_re;  assign ifc.x0_re    = d_x0_re;
    assign ifa.x0_im    = d_x0_im;  assign ifb.x0_im    = d_x0_im;  assign ifc.x0_im    = d_x0_im;
    assign ifa.x1_re    = d_x1_re;  assign ifb.x1_re    = d_x1_re;  assign ifc.x1_re    = d_x1_re;
    assign ifa.x1_im    = d_x1_im;  assign ifb.x1_im    = d_x1_im;  assign ifc.x1_im    = d_x1_im;
    assign ifa.conj_x1  = d_conj;   assign ifb.conj_x1  = d_conj;   assign ifc.conj_x1  = d_conj;
    assign ifa.out_ready = d_ready; assign ifb.out_ready = d_ready; assign ifc.out_ready = d_ready;

    complex_mult_pipe #(.DW(16), .FRAC(15), .USE_GAUSS(0), .ROUND(1)) dut_a (.clk(clk), .rst(d_rst), .bus(ifa));
    complex_mult_pipe #(.DW(16), .FRAC(15), .USE_GAUSS(1), .ROUND(1)) dut_b (.clk(clk), .rst(d_rst), .bus(ifb));
    complex_mult_pipe #(.DW(16), .FRAC(15), .USE_GAUSS(1), .ROUND(0)) dut_c (.clk(clk), .rst(d_rst), .bus(ifc));

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_t[$];
    int total = 0;
    int bad   = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference: plain integer arithmetic, result packed as {sat, re, im}
    function automatic logic [W-1:0] model(input int x0r, input int x0i, input int x1r,
                                           input int x1i, input bit conj, input bit rnd);
        longint b, re, im;
        logic [15:0] ore, oim;
        bit s;
        b  = conj ? ((x1i == -32768) ? 32767 : -x1i) : x1i;
        re = longint'(x0r) * x1r - longint'(x0i) * b;
        im = longint'(x0r) * b   + longint'(x0i) * x1r;
        re = (re + (rnd ? 16384 : 0)) >>> 15;
        im = (im + (rnd ? 16384 : 0)) >>> 15;
        s  = 0;
        if (re > 32767)  begin re = 32767;  s = 1; end
        if (re < -32768) begin re = -32768; s = 1; end
        if (im > 32767)  begin im = 32767;  s = 1; end
        if (im < -32768) begin im = -32768; s = 1; end
        ore = re[15:0];
        oim = im[15:0];
        return {s, ore, oim};
    endfunction

    // one cycle: sample handshakes before the edge, update scoreboard, move to next negedge
    task automatic tick(output bit acc);
        #2;
        acc = d_valid && ifa.in_ready && !d_rst;
        chk("ctl_eq", {ifb.in_ready, ifb.out_valid, ifc.in_ready, ifc.out_valid},
                      {ifa.in_ready, ifa.out_valid, ifa.in_ready, ifa.out_valid});
        if (!d_rst && ifa.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_out", 1, 0);
            end else begin
                chk("res_four",  {ifa.sat, ifa.res_re, ifa.res_im}, exp_q[0]);
                chk("res_gauss", {ifb.sat, ifb.res_re, ifb.res_im}, exp_q[0]);
                chk("res_trunc", {ifc.sat, ifc.res_re, ifc.res_im}, exp_t[0]);
                if (d_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                    n_out++;
                end
            end
        end
        if (acc) begin
            exp_q.push_back(model(d_x0_re, d_x0_im, d_x1_re, d_x1_im, d_conj, 1'b1));
            exp_t.push_back(model(d_x0_re, d_x0_im, d_x1_re, d_x1_im, d_conj, 1'b0));
        end
        if (d_rst) begin
            exp_q.delete();
            exp_t.delete();
        end
        @(negedge clk);
    endtask

    // driver tasks
    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic new_vec();
        d_x0_re = rnd16();
        d_x0_im = rnd16();
        d_x1_re = rnd16();
        d_x1_im = rnd16();
        d_conj  = 1'($urandom_range(0, 1));
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input bit cj);
        bit acc;
        d_x0_re = a; d_x0_im = b; d_x1_re = c; d_x1_im = d; d_conj = cj;
        d_valid = 1'b1;
        tick(acc);
        chk("send_acc", acc, 1);
        d_valid = 1'b0;
    endtask

    task automatic wait_out3();
        bit acc;
        tick(acc);
        chk("lat_edge2", ifa.out_valid, 0);
        tick(acc);
        chk("lat_edge3", ifa.out_valid, 1);
    endtask

    initial begin
        bit acc;
        int sent, stall, base, accepted, cyc;
        bit seen, drop;

        d_rst = 1'b1; d_valid = 1'b0; d_ready = 1'b1; d_conj = 1'b0;
        d_x0_re = '0; d_x0_im = '0; d_x1_re = '0; d_x1_im = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_state", {ifa.out_valid, ifa.sat, ifa.res_re, ifa.res_im}, 0);
        d_rst = 1'b0;
        #1;
        chk("post_rst_ready", ifa.in_ready, 1);

        // basic product, exact latency
        send1(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0);
        wait_out3();
        chk("r033", {ifa.sat, ifa.res_re, ifa.res_im}, {1'b0, 16'h4000, 16'h0000});
        tick(acc);

        // (-1)*(-1) saturates
        send1(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
        wait_out3();
        chk("r034", {ifa.sat, ifa.res_re, ifa.res_im}, {1'b1, 16'h7FFF, 16'h0000});
        tick(acc);

        // conjugate of -1j clamps internally, rounding vs floor
        send1(16'h4000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        wait_out3();
        chk("r035_round", {ifa.sat, ifa.res_re, ifa.res_im}, {1'b0, 16'h0000, 16'h4000});
        chk("r035_trunc", {ifc.sat, ifc.res_re, ifc.res_im}, {1'b0, 16'h0000, 16'h3FFF});
        tick(acc);

        // backpressure: six beats, output stalled five cycles from first valid
        sent = 0; stall = 0; seen = 0; drop = 0; base = n_out;
        new_vec();
        for (int c = 0; c < 40; c++) begin
            d_valid = (sent < 6);
            if (ifa.out_valid) seen = 1;
            d_ready = !(seen && stall < 5);
            if (seen && stall < 5) stall++;
            #1;
            if (d_valid && !ifa.in_ready) drop = 1;
            tick(acc);
            if (acc) begin
                sent++;
                new_vec();
            end
        end
        d_valid = 1'b0; d_ready = 1'b1;
        chk("bp_ready_drop", drop, 1);
        chk("bp_sent", sent, 6);
        chk("bp_count", n_out - base, 6);

        // reset with two beats in flight
        base = n_out;
        new_vec(); d_valid = 1'b1; tick(acc);
        new_vec(); tick(acc);
        d_valid = 1'b0;
        d_rst = 1'b1;
        #1;
        chk("midrst_ready", ifa.in_ready, 0);
        tick(acc);
        chk("midrst_ov", ifa.out_valid, 0);
        d_rst = 1'b0;
        #1;
        chk("midrst_ready1", ifa.in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            tick(acc);
            chk("midrst_noout", ifa.out_valid, 0);
        end
        chk("midrst_count", n_out - base, 0);
        send1(16'h2000, 16'hE000, 16'h7FFF, 16'h1234, 1'b1);
        wait_out3();
        tick(acc);

        // random stream with random stalls
        accepted = 0; cyc = 0;
        d_valid = 1'b0;
        new_vec();
        while (accepted < 10000 && cyc < 60000) begin
            if (!d_valid) d_valid = ($urandom_range(0, 3) != 0);
            d_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            cyc++;
            if (acc) begin
                accepted++;
                d_valid = 1'b0;
                new_vec();
            end
        end
        chk("rand_accepted", accepted, 10000);
        d_valid = 1'b0; d_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick(acc);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
